packet_arbiter: RTL and testbench

PACKET_ARBITER -- requirements
Module: packet_arbiter

---
 rtl/packet_arbiter.sv | 134 +++++++++++++
 tb/tb_packet_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/packet_arbiter.sv
// packet_arbiter
//   Arbitrates PORTS level-sensitive requesters onto a single registered
//   one-hot grant. It supports round-robin or fixed priority. It can hold
//   each grant until it is released by acknowledge or by the request
//   dropping, or it can re-arbitrate on every clock edge.
//
// Ports
//   clk           : rising-edge clock
//   rst           : asynchronous, active-high reset (clears grant and mask)
//   request       : per-port request, level-sensitive
//   acknowledge   : per-port end-of-transfer pulse (only the granted bit matters)
//   grant         : registered one-hot grant
//   grant_valid   : high iff grant != 0
//   grant_encoded : binary index of the granted port, 0 when idle
module packet_arbiter #(
    parameter int PORTS                = 4,
    parameter int ARB_TYPE_ROUND_ROBIN = 1,
    parameter int ARB_BLOCK            = 1,
    parameter int ARB_BLOCK_ACK        = 1,
    parameter int LSB_HIGH_PRIORITY    = 1,
    localparam int LN                  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [LN-1:0]    grant_encoded
);

    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

    state_t           state_q,  state_nxt;
    logic [PORTS-1:0] grant_q,  grant_nxt;
    logic [LN-1:0]    enc_q,    enc_nxt;
    logic [PORTS-1:0] mask_q,   mask_nxt;

    logic [PORTS-1:0] masked;
    logic [PORTS-1:0] search;
    logic [LN-1:0]    win_idx;
    logic [PORTS-1:0] win_onehot;
    logic             release_now;

    // Index of the highest-priority set bit; 0 when vec is empty.
    function automatic logic [LN-1:0] first_index(input logic [PORTS-1:0] vec);
        logic [LN-1:0] idx;
        idx = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = PORTS - 1; i >= 0; i--)
                if (vec[i]) idx = LN'(i);
        end else begin
            for (int i = 0; i < PORTS; i++)
                if (vec[i]) idx = LN'(i);
        end
        return idx;
    endfunction

    // Round-robin mask after granting port k: only ports that come after k
    // in the search order stay enabled. An all-zero result makes the next
    // search fall back to the raw request, which wraps the rotation.
    function automatic logic [PORTS-1:0] mask_after(input logic [LN-1:0] k);
        logic [PORTS-1:0] m;
        m = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (LSB_HIGH_PRIORITY != 0)
                m[i] = (i > int'(k));
            else
                m[i] = (i < int'(k));
        end
        return m;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            enc_q   <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            enc_q   <= enc_nxt;
            mask_q  <= mask_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        masked     = request & mask_q;
        search     = (masked != '0) ? masked : request;
        win_idx    = first_index(search);
        win_onehot = '0;
        for (int i = 0; i < PORTS; i++)
            win_onehot[i] = (search != '0) && (LN'(i) == win_idx);

        release_now = 1'b1;
        if (state_q == GRANTED && ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0)
                release_now = |(acknowledge & grant_q);
            else
                release_now = ~|(request & grant_q);
        end

        state_nxt = state_q;
        grant_nxt = grant_q;
        enc_nxt   = enc_q;
        mask_nxt  = mask_q;

        // A release loads the next winner in the same edge, so there is no
        // idle bubble between back-to-back grants.
        if (release_now) begin
            if (search != '0) begin
                state_nxt = GRANTED;
                grant_nxt = win_onehot;
                enc_nxt   = win_idx;
                mask_nxt  = (ARB_TYPE_ROUND_ROBIN != 0) ? mask_after(win_idx) : '1;
            end else begin
                state_nxt = IDLE;
                grant_nxt = '0;
                enc_nxt   = '0;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        grant         = grant_q;
        grant_valid   = (state_q == GRANTED);
        grant_encoded = enc_q;
    end

endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter
//   Directed bench for packet_arbiter. It instantiates several parameter
//   variants that share one set of inputs. A table of vectors drives the
//   default configuration, and short hand-written sequences cover the other
//   variants and the asynchronous reset.
module tb_packet_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] request;
    logic [3:0] acknowledge;

    logic [3:0] g_def, g_fix, g_nb, g_rq, g_msb;
    logic [1:0] e_def, e_fix, e_nb, e_rq, e_msb;
    logic       v_def, v_fix, v_nb, v_rq, v_msb;
    logic [0:0] g_one;
    logic [0:0] e_one;
    logic       v_one;

    int checks = 0;
    int errors = 0;

    packet_arbiter u_def (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
        .grant(g_def), .grant_valid(v_def), .grant_encoded(e_def));

    packet_arbiter #(.ARB_TYPE_ROUND_ROBIN(0)) u_fix (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
        .grant(g_fix), .grant_valid(v_fix), .grant_encoded(e_fix));

    packet_arbiter #(.ARB_BLOCK(0)) u_nb (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
        .grant(g_nb), .grant_valid(v_nb), .grant_encoded(e_nb));

    packet_arbiter #(.ARB_BLOCK_ACK(0)) u_rq (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
        .grant(g_rq), .grant_valid(v_rq), .grant_encoded(e_rq));

    packet_arbiter #(.LSB_HIGH_PRIORITY(0)) u_msb (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
        .grant(g_msb), .grant_valid(v_msb), .grant_encoded(e_msb));

    packet_arbiter #(.PORTS(1)) u_one (
        .clk(clk), .rst(rst), .request(request[0:0]), .acknowledge(acknowledge[0:0]),
        .grant(g_one), .grant_valid(v_one), .grant_encoded(e_one));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic [3:0] g;
        logic [1:0] enc;
        logic       v;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        request = '0;
        acknowledge = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic apply(input logic [3:0] req, input logic [3:0] ack);
        request = req;
        acknowledge = ack;
        step();
    endtask

    initial begin
        // default config: round-robin, hold until acknowledge, LSB wins
        tbl[0]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[6]  = '{4'b1111, 4'b0010, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{4'b1111, 4'b0001, 4'b0100, 2'd2, 1'b1};
        tbl[8]  = '{4'b1011, 4'b0000, 4'b0100, 2'd2, 1'b1};
        tbl[9]  = '{4'b1011, 4'b0100, 4'b1000, 2'd3, 1'b1};
        tbl[10] = '{4'b0011, 4'b1000, 4'b0001, 2'd0, 1'b1};
        tbl[11] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1};
        tbl[12] = '{4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0};
        tbl[13] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[14] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
        tbl[15] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[16] = '{4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0};

        rst = 1'b1;
        request = '0;
        acknowledge = '0;
        #2;
        check("reset grant", 8'(g_def), 8'h0);
        check("reset valid", 8'(v_def), 8'h0);
        check("reset enc",   8'(e_def), 8'h0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].req, tbl[i].ack);
            check($sformatf("vec%0d grant", i), 8'(g_def), 8'(tbl[i].g));
            check($sformatf("vec%0d enc", i),   8'(e_def), 8'(tbl[i].enc));
            check($sformatf("vec%0d valid", i), 8'(v_def), 8'(tbl[i].v));
        end

        // fixed priority: port 0 wins every re-arbitration
        do_reset();
        apply(4'b0011, 4'b0000);
        check("fix grant0", 8'(g_fix), 8'h1);
        for (int i = 1; i < 4; i++) begin
            apply(4'b0011, 4'b0001);
            check($sformatf("fix grant%0d", i), 8'(g_fix), 8'h1);
        end

        // asynchronous reset in the middle of a grant
        do_reset();
        apply(4'b0110, 4'b0000);
        check("ar pre grant", 8'(g_def), 8'h2);
        apply(4'b0110, 4'b0010);
        check("ar held grant", 8'(g_def), 8'h4);
        #2 rst = 1'b1;
        #1;
        check("ar async grant", 8'(g_def), 8'h0);
        check("ar async valid", 8'(v_def), 8'h0);
        check("ar async enc",   8'(e_def), 8'h0);
        #1 rst = 1'b0;
        apply(4'b0110, 4'b0000);
        check("ar after grant", 8'(g_def), 8'h2);
        check("ar after enc",   8'(e_def), 8'h1);
        // the mask is now 1100; a reset must restore it to all-ones
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        apply(4'b0101, 4'b0000);
        check("ar mask restored", 8'(g_def), 8'h1);

        // re-arbitrate every cycle
        do_reset();
        apply(4'b0001, 4'b0000);
        check("nb grant0001", 8'(g_nb), 8'h1);
        apply(4'b0100, 4'b0000);
        check("nb grant0100", 8'(g_nb), 8'h4);
        check("nb enc0100",   8'(e_nb), 8'h2);
        apply(4'b0000, 4'b0000);
        check("nb grant0000", 8'(g_nb), 8'h0);
        check("nb valid0000", 8'(v_nb), 8'h0);

        // release when the granted request drops
        do_reset();
        apply(4'b0011, 4'b0000);
        check("rq grant", 8'(g_rq), 8'h1);
        apply(4'b0011, 4'b0001);
        check("rq ack ignored", 8'(g_rq), 8'h1);
        apply(4'b0010, 4'b0000);
        check("rq drop release", 8'(g_rq), 8'h2);

        // highest index wins, round-robin downward
        do_reset();
        apply(4'b1010, 4'b0000);
        check("msb grant", 8'(g_msb), 8'h8);
        check("msb enc",   8'(e_msb), 8'h3);
        apply(4'b1010, 4'b1000);
        check("msb rotate", 8'(g_msb), 8'h2);
        apply(4'b1010, 4'b0010);
        check("msb wrap", 8'(g_msb), 8'h8);

        // single port
        do_reset();
        apply(4'b0001, 4'b0000);
        check("one grant", 8'(g_one), 8'h1);
        check("one enc",   8'(e_one), 8'h0);
        check("one valid", 8'(v_one), 8'h1);
        apply(4'b0000, 4'b0001);
        check("one release", 8'(g_one), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
